// File: rtl/si_mac_neuron.sv
// Sequential signed MAC neuron: accumulates N_INPUTS X*W products at full precision,
// adds a bias, then saturates to 8 bits with optional ReLU. Valid/ready on both sides.
module si_mac_neuron #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 20,
    parameter int RELU_EN  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic signed [7:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] x,
    input  logic signed [7:0] w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [7:0] y,
    output logic              busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_BIAS  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CNT_W-1:0]  count_q, count_d;
    logic signed [7:0]        bias_q, bias_d;
    logic signed [7:0]        y_q, y_d;

    logic                     beat;
    logic                     last_beat;
    logic signed [15:0]       product;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  biased;
    logic                     sat_pos;
    logic                     sat_neg;
    logic signed [7:0]        sat_val;
    logic signed [7:0]        result;

    // ---------------- arithmetic ----------------
    assign beat      = in_valid & in_ready;
    assign last_beat = (count_q == CNT_W'(N_INPUTS - 1));
    assign product   = x * w;
    assign acc_sum   = acc_q + {{(ACC_W-16){product[15]}}, product};
    assign biased    = acc_q + {{(ACC_W-8){bias_q[7]}}, bias_q};

    // Out of range whenever the bits above bit 7 are not all copies of the sign.
    assign sat_pos = ~biased[ACC_W-1] & (|biased[ACC_W-2:7]);
    assign sat_neg =  biased[ACC_W-1] & ~(&biased[ACC_W-2:7]);

    always_comb begin
        sat_val = biased[7:0];
        if (sat_pos) begin
            sat_val = 8'sh7f;
        end else if (sat_neg) begin
            sat_val = 8'sh80;
        end
        result = sat_val;
        if ((RELU_EN != 0) && sat_val[7]) begin
            result = 8'sh00;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            bias_q  <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            bias_q  <= bias_d;
            y_q     <= y_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)                state_d = S_ACCUM;
            S_ACCUM: if (beat && last_beat)    state_d = S_BIAS;
            S_BIAS:                            state_d = S_OUT;
            S_OUT:   if (out_ready)            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        bias_d  = bias_q;
        y_d     = y_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    bias_d  = bias;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d   = acc_sum;
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_BIAS: begin
                y_d = result;
            end
            default: begin
            end
        endcase
    end

    // ---------------- outputs (decoded from registered state) ----------------
    always_comb begin
        in_ready  = (state_q == S_ACCUM);
        out_valid = (state_q == S_OUT);
        busy      = (state_q != S_IDLE);
        y         = y_q;
    end

endmodule
